// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_if
// Description : Stage handshake bundle between the core sequencer and the
//               five pipeline-stage engines (fetch, decode, exec, mem, wb).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   *_enabled      sequencer -> stage  one-cycle start pulse
//   *_completed    stage -> sequencer  stage-done level
//   is_mem_instr   decode -> sequencer load/store flag (taken with decode done)
//   is_jump_chosen exec -> sequencer   branch/jump taken (taken with exec done)
//   jump_dest      exec -> sequencer   32-bit jump target
// Modports
//   master : the sequencer side
//   slave  : the stage-engine side
// ============================================================================
interface core_sequencer_if;
  logic        fetch_enabled;
  logic        decode_enabled;
  logic        exec_enabled;
  logic        mem_enabled;
  logic        wb_enabled;

  logic        fetch_completed;
  logic        decode_completed;
  logic        exec_completed;
  logic        mem_completed;
  logic        wb_completed;

  logic        is_mem_instr;
  logic        is_jump_chosen;
  logic [31:0] jump_dest;

  modport master (
    output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
    input  fetch_completed, decode_completed, exec_completed, mem_completed,
           wb_completed,
    input  is_mem_instr, is_jump_chosen, jump_dest
  );

  modport slave (
    input  fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
    output fetch_completed, decode_completed, exec_completed, mem_completed,
           wb_completed,
    output is_mem_instr, is_jump_chosen, jump_dest
  );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle instruction sequencer. Walks each instruction
//               through FETCH -> DECODE -> EXEC -> (MEM) -> WB, pulsing the
//               matching stage enable on entry and advancing when that
//               stage reports completion. Tracks pc and retired-instruction
//               count, supports halting between instructions and traps
//               terminally on a misaligned taken jump.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state changes on rising edge
//   rstn       in   synchronous active-low reset
//   halt       in   stop after the current instruction retires
//   bus        --   stage handshake bundle (core_sequencer_if.master)
//   pc         out  address of the instruction in flight
//   state      out  FSM state encoding
//   instret    out  retired-instruction count
//   misaligned out  sticky: a taken jump target was not 4-byte aligned
// ============================================================================
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             halt,
  core_sequencer_if.master bus,
  output logic [31:0]      pc,
  output logic [2:0]       state,
  output logic [31:0]      instret,
  output logic             misaligned
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  // Bit positions inside the enable vector.
  localparam int EN_FETCH  = 0;
  localparam int EN_DECODE = 1;
  localparam int EN_EXEC   = 2;
  localparam int EN_MEM    = 3;
  localparam int EN_WB     = 4;

  logic [2:0]  state_q,   state_d;
  logic [4:0]  en_q,      en_d;
  logic        start_q,   start_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instret_q, instret_d;
  logic        mis_q,     mis_d;
  logic        mem_q,     mem_d;
  logic        taken_q,   taken_d;
  logic [31:0] dest_q,    dest_d;

  logic        cur_done;
  logic        cur_busy;
  logic        accept;
  logic        jump_bad;

  // --------------------------------------------------------------------------
  // Select the completion of the stage we are in. A completion is not
  // accepted while the stage's start pulse is still on the wire, nor in
  // FETCH while the start pulse is still pending (start_q), since the
  // stage has not been told to begin yet.
  // --------------------------------------------------------------------------
  always_comb begin
    cur_done = 1'b0;
    cur_busy = 1'b0;
    case (state_q)
      ST_FETCH: begin
        cur_done = bus.fetch_completed;
        cur_busy = en_q[EN_FETCH] | start_q;
      end
      ST_DECODE: begin
        cur_done = bus.decode_completed;
        cur_busy = en_q[EN_DECODE];
      end
      ST_EXEC: begin
        cur_done = bus.exec_completed;
        cur_busy = en_q[EN_EXEC];
      end
      ST_MEM: begin
        cur_done = bus.mem_completed;
        cur_busy = en_q[EN_MEM];
      end
      ST_WB: begin
        cur_done = bus.wb_completed;
        cur_busy = en_q[EN_WB];
      end
      default: begin
        cur_done = 1'b0;
        cur_busy = 1'b1;
      end
    endcase
  end

  assign accept   = cur_done & ~cur_busy;
  assign jump_bad = bus.is_jump_chosen & (bus.jump_dest[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // Next-state logic. Enables are registered and default to zero, so each
  // one is high only in the first cycle after the transition that set it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    en_d      = 5'b0_0000;
    start_d   = 1'b0;
    pc_d      = pc_q;
    instret_d = instret_q;
    mis_d     = mis_q;
    mem_d     = mem_q;
    taken_d   = taken_q;
    dest_d    = dest_q;

    case (state_q)
      ST_FETCH: begin
        if (start_q) begin
          // Entered from reset or HALTED: issue the fetch pulse now.
          en_d[EN_FETCH] = 1'b1;
        end else if (accept) begin
          state_d         = ST_DECODE;
          en_d[EN_DECODE] = 1'b1;
        end
      end

      ST_DECODE: begin
        if (accept) begin
          mem_d         = bus.is_mem_instr;
          state_d       = ST_EXEC;
          en_d[EN_EXEC] = 1'b1;
        end
      end

      ST_EXEC: begin
        if (accept) begin
          taken_d = bus.is_jump_chosen;
          dest_d  = bus.jump_dest;
          if (jump_bad) begin
            // Misaligned taken target: stop here, never reach MEM/WB.
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else if (mem_q) begin
            state_d      = ST_MEM;
            en_d[EN_MEM] = 1'b1;
          end else begin
            state_d     = ST_WB;
            en_d[EN_WB] = 1'b1;
          end
        end
      end

      ST_MEM: begin
        if (accept) begin
          state_d     = ST_WB;
          en_d[EN_WB] = 1'b1;
        end
      end

      ST_WB: begin
        if (accept) begin
          // Retire: pc and instret both wrap naturally at 32 bits.
          pc_d      = taken_q ? dest_q : pc_q + 32'd4;
          instret_d = instret_q + 32'd1;
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d        = ST_FETCH;
            en_d[EN_FETCH] = 1'b1;
          end
        end
      end

      ST_HALTED: begin
        if (!halt) begin
          // Fetch pulse follows one cycle later, from the FETCH state itself.
          state_d = ST_FETCH;
          start_d = 1'b1;
        end
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        // Unreachable encoding: restart cleanly at FETCH.
        state_d = ST_FETCH;
        start_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_FETCH;
      en_q      <= 5'b0_0000;
      start_q   <= 1'b1;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      mis_q     <= 1'b0;
      mem_q     <= 1'b0;
      taken_q   <= 1'b0;
      dest_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      start_q   <= start_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
      mem_q     <= mem_d;
      taken_q   <= taken_d;
      dest_q    <= dest_d;
    end
  end

  assign bus.fetch_enabled  = en_q[EN_FETCH];
  assign bus.decode_enabled = en_q[EN_DECODE];
  assign bus.exec_enabled   = en_q[EN_EXEC];
  assign bus.mem_enabled    = en_q[EN_MEM];
  assign bus.wb_enabled     = en_q[EN_WB];

  assign pc         = pc_q;
  assign state      = state_q;
  assign instret    = instret_q;
  assign misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer. A stimulus process
//               plays the stage engines with random completion delays and
//               stray pulses, and pushes expected observable events (stage
//               enables, HALTED/TRAP entry) into a queue; a monitor pops and
//               compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        halt;
  logic [31:0] pc;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        misaligned;

  always #5 clk = ~clk;

  core_sequencer_if sif ();

  core_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .halt       (halt),
    .bus        (sif.master),
    .pc         (pc),
    .state      (state),
    .instret    (instret),
    .misaligned (misaligned)
  );

  typedef struct {
    logic [4:0]  en;    // expected enable one-hot (0 for a state-entry event)
    logic [2:0]  st;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        mis;
    int          gap;   // cycles since previous event, -1 = not checked
  } exp_t;

  exp_t        expq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] pc_m;
  logic [31:0] ir_m;
  logic        mis_m;
  bit          need_fetch;
  bit          aborted  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {sif.wb_enabled, sif.mem_enabled, sif.exec_enabled,
            sif.decode_enabled, sif.fetch_enabled};
  endfunction

  task automatic set_comp(input int s, input logic v);
    case (s)
      0: sif.fetch_completed  = v;
      1: sif.decode_completed = v;
      2: sif.exec_completed   = v;
      3: sif.mem_completed    = v;
      default: sif.wb_completed = v;
    endcase
  endtask

  task automatic garbage();
    sif.is_mem_instr   = 1'($urandom_range(0, 1));
    sif.is_jump_chosen = 1'($urandom_range(0, 1));
    sif.jump_dest      = $urandom();
    halt               = 1'($urandom_range(0, 1));
  endtask

  task automatic push_en(input int stg, input int gap);
    exp_t e;
    e.en  = 5'b00001 << stg;
    e.st  = 3'(stg);
    e.pc  = pc_m;
    e.ir  = ir_m;
    e.mis = mis_m;
    e.gap = gap;
    expq.push_back(e);
  endtask

  task automatic push_state(input logic [2:0] st, input int gap);
    exp_t e;
    e.en  = 5'b00000;
    e.st  = st;
    e.pc  = pc_m;
    e.ir  = ir_m;
    e.mis = mis_m;
    e.gap = gap;
    expq.push_back(e);
  endtask

  // Monitor: every negedge, any enable or entry into HALTED/TRAP is an event.
  initial begin
    int         cyc  = 0;
    int         last = 0;
    logic [2:0] prev = 3'd0;
    logic [4:0] ev;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      ev = en_vec();
      if (rstn === 1'b1 &&
          (ev != 5'b0 || (state != prev && (state == 3'd5 || state == 3'd6)))) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual en=%b state=%0d required=no_event", ev, state);
        end else begin
          e = expq.pop_front();
          check("event_enables",    32'(ev),         32'(e.en));
          check("event_state",      32'(state),      32'(e.st));
          check("event_pc",         pc,              e.pc);
          check("event_instret",    instret,         e.ir);
          check("event_misaligned", 32'(misaligned), 32'(e.mis));
          if (e.gap >= 0) check("event_latency", 32'(cyc - last), 32'(e.gap));
        end
        last = cyc;
      end
      prev = state;
    end
  end

  // Plays one stage: waits for its enable, then completes after d cycles
  // (d=0 means completed is already high during the enable cycle).
  task automatic run_stage(input int stg, input int d, input logic v_mem,
                           input logic v_jmp, input logic [31:0] v_dest,
                           input logic v_halt);
    bit         seen = 0;
    logic [4:0] ev;
    int         other;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ev = en_vec();
      if (ev[stg]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL stage_timeout stage=%0d actual=no_enable required=enable", stg);
      aborted = 1;
      return;
    end
    other = (stg + 1 + int'($urandom_range(0, 3))) % 5;
    for (int i = 0; i < d; i++) begin
      if (i == d - 1) set_comp(other, 1'b1);   // stray pulse of a foreign stage
      garbage();
      @(negedge clk);
      set_comp(other, 1'b0);
    end
    sif.is_mem_instr   = v_mem;
    sif.is_jump_chosen = v_jmp;
    sif.jump_dest      = v_dest;
    halt               = v_halt;
    set_comp(stg, 1'b1);
    repeat ((d == 0) ? 2 : 1) @(posedge clk);
    #1;
    set_comp(stg, 1'b0);
  endtask

  task automatic do_instr(input logic mem, input logic jmp, input logic [31:0] dest,
                          input logic hlt, input int dforce);
    int d[5];
    int g[5];
    for (int i = 0; i < 5; i++) begin
      d[i] = (dforce >= 0) ? dforce : int'($urandom_range(0, 2));
      g[i] = (d[i] == 0) ? 2 : d[i] + 1;
    end
    if (need_fetch) begin
      push_en(0, -1);
      need_fetch = 0;
    end
    push_en(1, g[0]);
    run_stage(0, d[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
              1'($urandom_range(0, 1)));
    if (aborted) return;
    push_en(2, g[1]);
    run_stage(1, d[1], mem, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
    if (aborted) return;
    if (jmp && dest[1:0] != 2'b00) begin
      mis_m = 1'b1;
      push_state(3'd6, g[2]);
      run_stage(2, d[2], 1'($urandom_range(0, 1)), jmp, dest, 1'($urandom_range(0, 1)));
      return;
    end
    if (mem) begin
      push_en(3, g[2]);
      run_stage(2, d[2], 1'($urandom_range(0, 1)), jmp, dest, 1'($urandom_range(0, 1)));
      if (aborted) return;
      push_en(4, g[3]);
      run_stage(3, d[3], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                1'($urandom_range(0, 1)));
    end else begin
      push_en(4, g[2]);
      run_stage(2, d[2], 1'($urandom_range(0, 1)), jmp, dest, 1'($urandom_range(0, 1)));
    end
    if (aborted) return;
    pc_m = jmp ? dest : pc_m + 32'd4;
    ir_m = ir_m + 32'd1;
    if (hlt) begin
      push_state(3'd5, g[4]);
      need_fetch = 1;
    end else begin
      push_en(0, g[4]);
    end
    run_stage(4, d[4], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), hlt);
    if (hlt) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    halt = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    halt = 1'b0;
    for (int s = 0; s < 5; s++) set_comp(s, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",      32'(state),      32'd0);
    check("reset_pc",         pc,              RESET_PC);
    check("reset_instret",    instret,         32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check("reset_enables",    32'(en_vec()),   32'd0);
    expq.delete();
    pc_m  = RESET_PC;
    ir_m  = 32'd0;
    mis_m = 1'b0;
    push_en(0, -1);
    need_fetch = 0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("fetch_after_reset", 32'(sif.fetch_enabled), 32'd1);
  endtask

  function automatic logic [31:0] rand_dest();
    logic [31:0] r;
    r = $urandom();
    return {r[31:2], 2'b00};
  endfunction

  initial begin
    logic [4:0] ev;
    bit         seen;
    garbage();
    halt = 1'b0;
    do_reset();

    // Plain instruction with one-cycle completions, then memory + jump.
    do_instr(1'b0, 1'b0, 32'h0, 1'b0, 1);
    do_instr(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1);
    // pc wrap: jump to the last word, then fall through to 0.
    do_instr(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, -1);
    do_instr(1'b1, 1'b0, 32'h0, 1'b0, -1);
    // Halt, then resume.
    do_instr(1'b0, 1'b0, 32'h0, 1'b1, 1);
    do_instr(1'b0, 1'b0, 32'h0, 1'b0, 1);

    for (int n = 0; n < 40 && !aborted; n++)
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_dest(),
               1'($urandom_range(0, 3) == 0), -1);

    // Reset in the middle of EXEC.
    if (!aborted) begin
      if (need_fetch) begin
        push_en(0, -1);
        need_fetch = 0;
      end
      push_en(1, -1);
      run_stage(0, 1, 1'b0, 1'b0, 32'h0, 1'b0);
      push_en(2, -1);
      run_stage(1, 1, 1'b0, 1'b0, 32'h0, 1'b0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        ev = en_vec();
        if (ev[2]) begin
          seen = 1;
          break;
        end
      end
      check("exec_seen_before_reset", 32'(seen), 32'd1);
      #2;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("midexec_reset_state",   32'(state),    32'd0);
      check("midexec_reset_pc",      pc,            RESET_PC);
      check("midexec_reset_instret", instret,       32'd0);
      check("midexec_reset_enables", 32'(en_vec()), 32'd0);
      do_reset();
    end

    for (int n = 0; n < 6 && !aborted; n++)
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_dest(),
               1'b0, -1);

    // Misaligned taken jump: terminal trap, later pulses ignored.
    if (!aborted) begin
      do_instr(1'b1, 1'b1, 32'h0000_0102, 1'b0, 1);
      for (int i = 0; i < 6; i++) begin
        for (int s = 0; s < 5; s++) set_comp(s, 1'($urandom_range(0, 1)));
        halt = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      for (int s = 0; s < 5; s++) set_comp(s, 1'b0);
      halt = 1'b0;
      @(negedge clk);
      check("trap_state",      32'(state),      32'd6);
      check("trap_pc",         pc,              pc_m);
      check("trap_instret",    instret,         ir_m);
      check("trap_misaligned", 32'(misaligned), 32'd1);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
